// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, state
// encoding and ALU mux codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_R_WB     = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_LW_WB    = 4'd6;
    localparam logic [3:0] ST_MEM_WR   = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;

    typedef enum logic [3:0] {
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        EXEC_R   = ST_EXEC_R,
        R_WB     = ST_R_WB,
        MEM_ADDR = ST_MEM_ADDR,
        MEM_RD   = ST_MEM_RD,
        LW_WB    = ST_LW_WB,
        MEM_WR   = ST_MEM_WR,
        BRANCH   = ST_BRANCH
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (R-type, lw, sw, beq) for a shared-memory
// datapath, with a watchdog on every memory handshake.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TO = 15,
    parameter int TO_W   = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       InstDone,
    output logic       IllegalInst,
    output logic       MemErr
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TO);

    state_t            state;
    state_t            state_next;
    logic [TO_W-1:0]   wait_cnt;
    logic [6:0]        opc_q;
    logic              is_wait;
    logic              timeout;
    logic              retire;
    logic              illegal;

    // Zero qualifies PCWriteCond inside the datapath; the sequencer ignores it.
    logic unused_zero;
    assign unused_zero = Zero;

    assign is_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // The access is abandoned on the wait cycle that would take the counter to MEM_TO.
    assign timeout = is_wait && !MemReady && (wait_cnt >= TO_LAST);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        state_next  = state;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM;
                case (Opcode)
                    OPC_R:                state_next = EXEC_R;
                    OPC_LOAD, OPC_STORE:  state_next = MEM_ADDR;
                    OPC_BRANCH:           state_next = BRANCH;
                    default: begin
                        state_next = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                state_next = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opc_q == OPC_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)     state_next = LW_WB;
                else if (timeout) state_next = FETCH;
            end
            LW_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            opc_q       <= '0;
            MemErr      <= 1'b0;
            InstDone    <= 1'b0;
            IllegalInst <= 1'b0;
        end else begin
            state       <= state_next;
            InstDone    <= retire;
            IllegalInst <= illegal;
            if (timeout)
                MemErr <= 1'b1;
            if (state == DECODE)
                opc_q <= Opcode;
            // Every transition (and a FETCH->FETCH timeout restart) starts a fresh wait.
            if (state_next != state || timeout)
                wait_cnt <= '0;
            else if (is_wait && !MemReady && wait_cnt != TO_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model
// queues the expected control word of every cycle; a monitor compares them.
module tb_multicycle_ctrl;

    localparam int MEM_TO = 15;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [6:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       MemtoReg, RegWrite, InstDone, IllegalInst, MemErr;

    multicycle_ctrl #(.MEM_TO(MEM_TO), .TO_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .InstDone(InstDone), .IllegalInst(IllegalInst), .MemErr(MemErr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       memto_reg, reg_write, inst_done, illegal_inst, mem_err;
    } ctl_t;

    typedef struct {
        logic       ready;
        logic [6:0] opc;
        logic       zero;
    } drv_t;

    ctl_t exp_q[$];
    drv_t drv_q[$];
    bit   done_pend, ill_pend, err_model, started;
    int   checks, errors, cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Expected control word of each phase, straight from the output table.
    function automatic ctl_t word(input string ph);
        ctl_t c;
        c = '0;
        case (ph)
            "fetch":      begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            "fetch_done": begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
            "decode":     c.alu_src_b = 2'b10;
            "exec_r":     begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            "r_wb":       c.reg_write = 1'b1;
            "mem_addr":   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            "mem_rd":     begin c.mem_read = 1'b1; c.iord = 1'b1; end
            "lw_wb":      begin c.reg_write = 1'b1; c.memto_reg = 1'b1; end
            "mem_wr":     begin c.mem_write = 1'b1; c.iord = 1'b1; end
            "branch":     begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1; end
            default:      c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] rand_opc();
        logic [31:0] r;
        r = $urandom();
        return r[6:0];
    endfunction

    task automatic push_cycle(input ctl_t c, input logic rdy, input logic [6:0] opc);
        ctl_t e;
        drv_t d;
        e = c;
        e.inst_done    = done_pend;
        e.illegal_inst = ill_pend;
        e.mem_err      = err_model;
        done_pend = 1'b0;
        ill_pend  = 1'b0;
        d.ready = rdy;
        d.opc   = opc;
        d.zero  = 1'($urandom());
        exp_q.push_back(e);
        drv_q.push_back(d);
    endtask

    // A handshake with 'waits' not-ready cycles; MEM_TO or more waits aborts it.
    task automatic mem_phase(input ctl_t base, input ctl_t fin, input int waits, output bit ok);
        if (waits >= MEM_TO) begin
            for (int i = 0; i < MEM_TO; i++) push_cycle(base, 1'b0, rand_opc());
            err_model = 1'b1;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < waits; i++) push_cycle(base, 1'b0, rand_opc());
            push_cycle(ctl_t'(base | fin), 1'b1, rand_opc());
            ok = 1'b1;
        end
    endtask

    task automatic plan_instr(input logic [6:0] opc, input int fetch_waits, input int mem_waits);
        bit ok;
        int fw;
        fw = fetch_waits;
        do begin
            mem_phase(word("fetch"), word("fetch_done"), fw, ok);
            fw = $urandom_range(0, 2);
        end while (!ok);
        push_cycle(word("decode"), 1'($urandom()), opc);
        case (opc)
            7'b0110011: begin
                push_cycle(word("exec_r"), 1'($urandom()), rand_opc());
                push_cycle(word("r_wb"), 1'($urandom()), rand_opc());
                done_pend = 1'b1;
            end
            7'b0000011: begin
                push_cycle(word("mem_addr"), 1'($urandom()), rand_opc());
                mem_phase(word("mem_rd"), '0, mem_waits, ok);
                if (ok) begin
                    push_cycle(word("lw_wb"), 1'($urandom()), rand_opc());
                    done_pend = 1'b1;
                end
            end
            7'b0100011: begin
                push_cycle(word("mem_addr"), 1'($urandom()), rand_opc());
                mem_phase(word("mem_wr"), '0, mem_waits, ok);
                if (ok) done_pend = 1'b1;
            end
            7'b1100011: begin
                push_cycle(word("branch"), 1'($urandom()), rand_opc());
                done_pend = 1'b1;
            end
            default: ill_pend = 1'b1;
        endcase
    endtask

    function automatic int pick_waits();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5) return $urandom_range(0, 2);
        if (sel == 6) return $urandom_range(3, 6);
        if (sel == 7) return MEM_TO - 1;
        if (sel == 8) return MEM_TO;
        return 0;
    endfunction

    function automatic logic [6:0] pick_opc();
        case ($urandom_range(0, 5))
            0: return 7'b0110011;
            1: return 7'b0000011;
            2: return 7'b0100011;
            3: return 7'b1100011;
            4: return 7'b1101111;
            default: return rand_opc();
        endcase
    endfunction

    // Monitor: one expected word per cycle, sampled mid-cycle.
    initial begin
        ctl_t got, want;
        wait (started);
        forever begin
            @(negedge Clk);
            if (exp_q.size() != 0) begin
                got = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA,
                       ALUSrcB, ALUOp, MemtoReg, RegWrite, InstDone, IllegalInst, MemErr};
                want = exp_q.pop_front();
                check("ctl_word", 32'(got), 32'(want));
                cyc++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d expected words left", exp_q.size());
        $fatal(1);
    end

    initial begin
        drv_t d;
        // Directed sequences first, then a random program.
        plan_instr(7'b0110011, 0, 0);
        plan_instr(7'b0000011, 0, 3);
        plan_instr(7'b1100011, 0, 0);
        plan_instr(7'b1101111, 0, 0);
        plan_instr(7'b0100011, 0, MEM_TO);
        plan_instr(7'b0100011, 0, MEM_TO - 1);
        plan_instr(7'b0000011, MEM_TO, 0);
        for (int i = 0; i < 60; i++) plan_instr(pick_opc(), pick_waits(), pick_waits());
        push_cycle(word("fetch"), 1'b0, rand_opc());

        @(negedge Clk);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_iord", 32'(IorD), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_pulses_err", 32'({InstDone, IllegalInst, MemErr}), 32'd0);

        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        while (drv_q.size() != 0) begin
            d = drv_q.pop_front();
            MemReady = d.ready;
            Opcode   = d.opc;
            Zero     = d.zero;
            started  = 1'b1;
            @(posedge Clk);
            #1;
        end

        // Reset landing in the middle of a store handshake.
        MemReady = 1'b1; Opcode = 7'b0100011;
        @(posedge Clk); #1;
        MemReady = 1'b0;
        @(posedge Clk); #1;
        Opcode = rand_opc();
        @(posedge Clk); #1;
        @(negedge Clk);
        check("mw_write_before_rst", 32'({MemWrite, IorD}), 32'b11);
        check("mw_err_before_rst", 32'(MemErr), 32'(err_model));
        #2;
        Rst = 1'b1;
        #1;
        check("rst_async_memwrite", 32'(MemWrite), 32'd0);
        check("rst_async_iord", 32'(IorD), 32'd0);
        check("rst_async_memerr", 32'(MemErr), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rst_no_done", 32'({InstDone, IllegalInst}), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_fetch", 32'({MemRead, IorD, MemWrite, MemErr}), 32'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
